ifetch: RTL and testbench
=========================

Name: ifetch

Overview:
- Instruction-fetch responder: consumes the fetch address from `pc` and returns the instruction word.
- Sequence:
  - Translates the virtual address (kseg0/kseg1 strip).
  - Serves the word from a one-entry line buffer on a hit.
  - On a miss, runs a req/ack bus read and stalls the pipeline until data arrives.
- Sits between `pc` (`addr` output) and the memory bus.
- Raises fetch exceptions (AdEL, bus error) for cop0.

Parameters:
- BUS_TIMEOUT, default 255: max cycles in REQ without `bus_ack` before a bus error is declared; 8-bit counter.
- BOOT_ADDR, default 32'h9fc00000: reset value of the buffer tag. The buffer resets invalid; the tag is used only for debug reads.

Ports:
- clk  in  1  system clock, rising edge
- rest  in  1  synchronous active-high reset
- addr  in  32  virtual fetch address from pc
- flush  in  1  pipeline redirect; invalidate buffer and discard any pending response
- inst  out  32  instruction word, valid when `inst_valid`
- inst_valid  out  1  `inst` corresponds to the current `addr`
- stall  out  1  hold pc and decode this cycle
- adel  out  1  misaligned fetch (addr[1:0] != 0), combinational
- ibe  out  1  one-cycle pulse: bus error or timeout on a demand fetch
- bad_vaddr  out  32  faulting virtual address; valid with `adel`/`ibe`
- bus_req  out  1  read request; held until `bus_ack`
- bus_addr  out  32  physical read address; stable while `bus_req`=1
- bus_ack  in  1  data valid / request accepted (same cycle)
- bus_rdata  in  32  read data, sampled when `bus_ack`=1
- bus_err  in  1  error response, sampled when `bus_ack`=1

Behaviour:
- Reset: sync on rest=1, rest dominates all other inputs.
  - State IDLE, buffer invalid, timeout counter 0.
  - Outputs: `bus_req`=0, `bus_addr`=0, `ibe`=0, `inst_valid`=0, `inst`=0.
  - `stall` is 0 during reset.
- Address translation:
  - addr[31:29] in {3'b100, 3'b101}: phys = {3'b000, addr[28:0]}.
  - Otherwise phys = addr; no TLB.
- Hit:
  - Condition: buffer valid, tag == addr[31:2], not adel.
  - Same cycle: `inst`=buffer data, `inst_valid`=1, `stall`=0.
- adel:
  - `adel`=1, `bad_vaddr`=addr, `inst`=0, `inst_valid`=0, `stall`=0.
  - No bus request.
- FSM states: IDLE, REQ, DONE.
  - IDLE: a miss (not adel, not flush) sets `stall`=1 and moves to REQ next cycle. `bus_addr` latches phys, `bus_req` goes to 1, and the counter clears.
  - REQ: `stall`=1, counter increments each cycle.
    - `bus_ack`=1, `bus_err`=0: write buffer (tag, `bus_rdata`), go to DONE.
    - `bus_ack`=1, `bus_err`=1: no write; `ibe`=1 next cycle, `bad_vaddr`=request vaddr; go to IDLE.
    - Counter == BUS_TIMEOUT without ack: same as `bus_err`; drop `bus_req`.
  - DONE: one cycle with `stall`=0 and a hit; return to IDLE.
- Miss latency: ack cycle + 1. With the ack in the first REQ cycle, `stall` is high for exactly 2 cycles.
- flush:
  - Invalidates the buffer the same cycle; `inst_valid`=0.
  - In REQ, the bus handshake completes (`bus_req` held until ack), but data and error are discarded and no `ibe` is raised. Then IDLE.
- addr change during REQ is ignored until DONE. pc is stalled, so a change implies a flush.
- rest mid-REQ: drop `bus_req` immediately. The bus must tolerate an abandoned request.

Optional Feature:
- Macro: IFETCH_PREFETCH_EN.
- Enabled:
  - Adds a second entry and state PREF.
  - After DONE, if the bus is idle, FSM issues a speculative read of vaddr+4 (translated) into entry 1.
  - Hit on either entry serves the word.
  - A demand miss during PREF: `stall`=1 until the prefetch ack, then a normal REQ.
  - Prefetch `bus_err`/timeout: the entry stays invalid and `ibe` is never raised.
  - flush invalidates both entries.
- Disabled: single entry; PREF state and logic are absent.

Decomposition:
- common.v gets:
  - State codes `IFS_IDLE`, `IFS_REQ`, `IFS_DONE`, `IFS_PREF`.
  - KSEG segment constants `KSEG0_HI`=3'b100, `KSEG1_HI`=3'b101.
- One sub-module `ifetch_xlate`: combinational vaddr->phys plus adel detect; reused later by the data-side load/store unit.

Test Plan:
1. Cold fetch:
   - Stimulus: rest then addr=9fc00000; ack on 1st REQ cycle with rdata=3c1d0001.
   - Required: `bus_addr`=1fc00000, `stall` high 2 cycles, then `inst`=3c1d0001, `inst_valid`=1.
2. Hit:
   - Stimulus: addr held at 9fc00000 after fill.
   - Required: `stall`=0, no `bus_req`, `inst` unchanged.
3. Misaligned:
   - Stimulus: addr=9fc00002.
   - Required: `adel`=1, `bad_vaddr`=9fc00002, `bus_req` stays 0, `stall`=0.
4. Bus error/timeout:
   - Stimulus: miss at bfc00010 with `bus_err`=1 on ack.
   - Required: one-cycle `ibe`, `bad_vaddr`=bfc00010, buffer invalid.
   - Repeat with no ack: `ibe` after 255 REQ cycles.
5. Flush mid-REQ:
   - Stimulus: flush in REQ, ack 3 cycles later.
   - Required: data not written, `ibe`=0, re-fetch of the new addr issues a new `bus_req`.
6. Prefetch (IFETCH_PREFETCH_EN):
   - Stimulus: after fill of 9fc00000.
   - Required: `bus_addr`=1fc00004 issued with no stall; next fetch of 9fc00004 hits with `stall`=0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction-fetch block: FSM state codes and KSEG segment bits.
// IFS_PREF is only reached when the block is built with IFETCH_PREFETCH_EN.
package ifetch_pkg;

    localparam logic [1:0] IFS_IDLE = 2'd0;
    localparam logic [1:0] IFS_REQ  = 2'd1;
    localparam logic [1:0] IFS_DONE = 2'd2;
    localparam logic [1:0] IFS_PREF = 2'd3;

    localparam logic [2:0] KSEG0_HI = 3'b100;
    localparam logic [2:0] KSEG1_HI = 3'b101;

    // kseg0/kseg1 are unmapped windows onto the low 512 MB; everything else passes through.
    function automatic logic [31:0] kseg_strip(input logic [31:0] vaddr);
        logic [31:0] paddr;
        paddr = vaddr;
        if (vaddr[31:29] == KSEG0_HI || vaddr[31:29] == KSEG1_HI) begin
            paddr = {3'b000, vaddr[28:0]};
        end
        return paddr;
    endfunction

endpackage

// File: rtl/ifetch_xlate.sv
// Combinational virtual-to-physical translation plus word-alignment check.
// Kept standalone so the load/store unit can reuse it.
module ifetch_xlate
    import ifetch_pkg::*;
(
    input  logic [31:0] vaddr,
    output logic [31:0] paddr,
    output logic        adel
);

    always_comb begin
        paddr = kseg_strip(vaddr);
        adel  = (vaddr[1:0] != 2'b00);
    end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch responder: one-entry line buffer in front of a req/ack bus read.
// Define IFETCH_PREFETCH_EN to add a second entry filled by a speculative next-word read.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [7:0]  BUS_TIMEOUT = 8'd255,
    parameter logic [31:0] BOOT_ADDR   = 32'h9fc0_0000
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] addr,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        stall,
    output logic        adel,
    output logic        ibe,
    output logic [31:0] bad_vaddr,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic [1:0]  dbg_state
);

    // Bus handshake: bus_req rises with a stable bus_addr and stays high until the
    // cycle bus_ack=1; that single cycle both accepts the request and returns
    // bus_rdata/bus_err. There is no separate response phase.

    logic [1:0]  state;
    logic [31:0] phys;
    logic        adel_x;

    logic        buf0_valid;
    logic [29:0] buf0_tag;
    logic [31:0] buf0_data;

    logic [31:0] req_vaddr;
    logic        req_q;
    logic [31:0] bus_addr_q;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;
    logic        discard;
    logic        ibe_q;

    logic        hit0;
    logic        hit;
    logic [31:0] hit_data;
    logic        miss;
    logic        timeout;

    ifetch_xlate u_xlate (
        .vaddr (addr),
        .paddr (phys),
        .adel  (adel_x)
    );

`ifdef IFETCH_PREFETCH_EN
    logic        buf1_valid;
    logic [29:0] buf1_tag;
    logic [31:0] buf1_data;
    logic        hit1;
    logic [31:0] pf_vaddr;
    logic [31:0] pf_paddr;
    logic        pf_adel;

    assign pf_vaddr = req_vaddr + 32'd4;

    ifetch_xlate u_xlate_pf (
        .vaddr (pf_vaddr),
        .paddr (pf_paddr),
        .adel  (pf_adel)
    );
`endif

    // A flush in the same cycle must already hide the buffer contents.
    always_comb begin
        hit0 = buf0_valid && (buf0_tag == addr[31:2]) && !adel_x && !flush;
`ifdef IFETCH_PREFETCH_EN
        hit1     = buf1_valid && (buf1_tag == addr[31:2]) && !adel_x && !flush;
        hit      = hit0 || hit1;
        hit_data = hit0 ? buf0_data : buf1_data;
`else
        hit      = hit0;
        hit_data = buf0_data;
`endif
        miss    = !adel_x && !flush && !hit;
        cnt_inc = cnt + 8'd1;
        // cnt_inc is the number of bus cycles spent waiting, including this one.
        timeout = !bus_ack && (cnt_inc == BUS_TIMEOUT);
    end

    always_comb begin
        inst_valid = hit && !rest;
        inst       = inst_valid ? hit_data : 32'd0;
        stall      = 1'b0;
        if (!rest) begin
            if (state == IFS_REQ) begin
                stall = 1'b1;
            end else begin
                stall = miss;
            end
        end
        adel      = adel_x;
        bad_vaddr = adel_x ? addr : req_vaddr;
        // Reset silences the bus at once rather than on the following edge.
        bus_req   = req_q && !rest;
        bus_addr  = rest ? 32'd0 : bus_addr_q;
        ibe       = ibe_q && !rest;
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state      <= IFS_IDLE;
            buf0_valid <= 1'b0;
            buf0_tag   <= BOOT_ADDR[31:2];
            buf0_data  <= 32'd0;
            req_vaddr  <= 32'd0;
            req_q      <= 1'b0;
            bus_addr_q <= 32'd0;
            cnt        <= 8'd0;
            discard    <= 1'b0;
            ibe_q      <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
            buf1_valid <= 1'b0;
            buf1_tag   <= BOOT_ADDR[31:2];
            buf1_data  <= 32'd0;
`endif
        end else begin
            ibe_q <= 1'b0;
            case (state)
                IFS_IDLE: begin
                    if (miss) begin
                        state      <= IFS_REQ;
                        req_vaddr  <= addr;
                        bus_addr_q <= phys;
                        req_q      <= 1'b1;
                        cnt        <= 8'd0;
                        discard    <= 1'b0;
                    end
                end
                IFS_REQ: begin
                    cnt <= cnt_inc;
                    if (flush) begin
                        discard <= 1'b1;
                    end
                    if (bus_ack || timeout) begin
                        req_q <= 1'b0;
                        if (discard || flush) begin
                            state <= IFS_IDLE;
                        end else if (bus_ack && !bus_err) begin
                            buf0_valid <= 1'b1;
                            buf0_tag   <= req_vaddr[31:2];
                            buf0_data  <= bus_rdata;
                            state      <= IFS_DONE;
                        end else begin
                            ibe_q <= 1'b1;
                            state <= IFS_IDLE;
                        end
                    end
                end
                IFS_DONE: begin
`ifdef IFETCH_PREFETCH_EN
                    if (!flush && !pf_adel) begin
                        state      <= IFS_PREF;
                        req_vaddr  <= pf_vaddr;
                        bus_addr_q <= pf_paddr;
                        req_q      <= 1'b1;
                        cnt        <= 8'd0;
                        discard    <= 1'b0;
                    end else begin
                        state <= IFS_IDLE;
                    end
`else
                    state <= IFS_IDLE;
`endif
                end
`ifdef IFETCH_PREFETCH_EN
                // Speculative read: failures leave entry 1 invalid and never trap.
                IFS_PREF: begin
                    cnt <= cnt_inc;
                    if (flush) begin
                        discard <= 1'b1;
                    end
                    if (bus_ack || timeout) begin
                        req_q <= 1'b0;
                        state <= IFS_IDLE;
                        if (bus_ack && !bus_err && !discard && !flush) begin
                            buf1_valid <= 1'b1;
                            buf1_tag   <= req_vaddr[31:2];
                            buf1_data  <= bus_rdata;
                        end
                    end
                end
`endif
                default: begin
                    state <= IFS_IDLE;
                end
            endcase
            if (flush) begin
                buf0_valid <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
                buf1_valid <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch: reset, cold fill, hit, misalign, bus error,
// timeout, flush mid-request, and the IFETCH_PREFETCH_EN next-word read when defined.
module tb_ifetch;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rest;
    logic [31:0] addr;
    logic        flush;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic [31:0] inst;
    logic        inst_valid;
    logic        stall;
    logic        adel;
    logic        ibe;
    logic [31:0] bad_vaddr;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ifetch dut (
        .clk        (clk),
        .rest       (rest),
        .addr       (addr),
        .flush      (flush),
        .inst       (inst),
        .inst_valid (inst_valid),
        .stall      (stall),
        .adel       (adel),
        .ibe        (ibe),
        .bad_vaddr  (bad_vaddr),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err),
        .dbg_state  (dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rest = 1'b1; addr = 32'h9fc0_0000; flush = 1'b0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
        step(); step(); settle();
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        n_cmp++; if (bus_addr !== 32'd0) begin n_bad++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
        n_cmp++; if (ibe !== 1'b0) begin n_bad++; $display("FAIL reset_ibe: got %b want 0", ibe); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        n_cmp++; if (inst !== 32'd0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", inst); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (dbg_state !== IFS_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IFS_IDLE); end
    endtask

    task automatic test_cold_fetch();
        int stall_cycles;
        stall_cycles = 0;
        rest = 1'b0; addr = 32'h9fc0_0000; settle();
        if (stall === 1'b1) stall_cycles++;
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL cold_idle_bus_req: got %b want 0", bus_req); end
        step();
        if (stall === 1'b1) stall_cycles++;
        n_cmp++; if (dbg_state !== IFS_REQ) begin n_bad++; $display("FAIL cold_state_req: got %0d want %0d", dbg_state, IFS_REQ); end
        n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL cold_bus_req: got %b want 1", bus_req); end
        n_cmp++; if (bus_addr !== 32'h1fc0_0000) begin n_bad++; $display("FAIL cold_bus_addr: got %h want 1fc00000", bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'h3c1d_0001;
        step();
        bus_ack = 1'b0; bus_rdata = 32'd0; settle();
        if (stall === 1'b1) stall_cycles++;
        n_cmp++; if (stall_cycles !== 2) begin n_bad++; $display("FAIL cold_stall_cycles: got %0d want 2", stall_cycles); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL cold_done_stall: got %b want 0", stall); end
        n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL cold_inst_valid: got %b want 1", inst_valid); end
        n_cmp++; if (inst !== 32'h3c1d_0001) begin n_bad++; $display("FAIL cold_inst: got %h want 3c1d0001", inst); end
        n_cmp++; if (dbg_state !== IFS_DONE) begin n_bad++; $display("FAIL cold_state_done: got %0d want %0d", dbg_state, IFS_DONE); end
    endtask

`ifdef IFETCH_PREFETCH_EN
    task automatic test_prefetch();
        step();
        n_cmp++; if (dbg_state !== IFS_PREF) begin n_bad++; $display("FAIL pf_state: got %0d want %0d", dbg_state, IFS_PREF); end
        n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL pf_bus_req: got %b want 1", bus_req); end
        n_cmp++; if (bus_addr !== 32'h1fc0_0004) begin n_bad++; $display("FAIL pf_bus_addr: got %h want 1fc00004", bus_addr); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL pf_stall: got %b want 0", stall); end
        bus_ack = 1'b1; bus_rdata = 32'h2408_0004;
        step();
        bus_ack = 1'b0; bus_rdata = 32'd0; addr = 32'h9fc0_0004; settle();
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL pf_hit_stall: got %b want 0", stall); end
        n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL pf_hit_valid: got %b want 1", inst_valid); end
        n_cmp++; if (inst !== 32'h2408_0004) begin n_bad++; $display("FAIL pf_hit_inst: got %h want 24080004", inst); end
        addr = 32'h9fc0_0000; settle();
    endtask
`endif

    task automatic test_hit();
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL hit_stall[%0d]: got %b want 0", i, stall); end
            n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL hit_bus_req[%0d]: got %b want 0", i, bus_req); end
            n_cmp++; if (inst !== 32'h3c1d_0001) begin n_bad++; $display("FAIL hit_inst[%0d]: got %h want 3c1d0001", i, inst); end
            n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL hit_valid[%0d]: got %b want 1", i, inst_valid); end
        end
    endtask

    task automatic test_misaligned();
        addr = 32'h9fc0_0002; settle();
        n_cmp++; if (adel !== 1'b1) begin n_bad++; $display("FAIL adel_flag: got %b want 1", adel); end
        n_cmp++; if (bad_vaddr !== 32'h9fc0_0002) begin n_bad++; $display("FAIL adel_bad_vaddr: got %h want 9fc00002", bad_vaddr); end
        n_cmp++; if (inst !== 32'd0) begin n_bad++; $display("FAIL adel_inst: got %h want 0", inst); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL adel_valid: got %b want 0", inst_valid); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL adel_stall[%0d]: got %b want 0", i, stall); end
            n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL adel_bus_req[%0d]: got %b want 0", i, bus_req); end
            step();
        end
    endtask

    task automatic test_bus_error();
        int req_cycles;
        addr = 32'hbfc0_0010; settle();
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL berr_miss_stall: got %b want 1", stall); end
        step();
        n_cmp++; if (bus_addr !== 32'h1fc0_0010) begin n_bad++; $display("FAIL berr_bus_addr: got %h want 1fc00010", bus_addr); end
        bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'hffff_ffff;
        step();
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0; settle();
        n_cmp++; if (ibe !== 1'b1) begin n_bad++; $display("FAIL berr_ibe: got %b want 1", ibe); end
        n_cmp++; if (bad_vaddr !== 32'hbfc0_0010) begin n_bad++; $display("FAIL berr_bad_vaddr: got %h want bfc00010", bad_vaddr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL berr_not_written: got %b want 0", inst_valid); end
        step();
        n_cmp++; if (ibe !== 1'b0) begin n_bad++; $display("FAIL berr_ibe_pulse: got %b want 0", ibe); end
        // The still-missing fetch relaunches; leave it unanswered to reach the timeout.
        req_cycles = 0;
        while (bus_req === 1'b1 && req_cycles < 400) begin
            req_cycles++;
            step();
        end
        n_cmp++; if (req_cycles !== 255) begin n_bad++; $display("FAIL tmo_req_cycles: got %0d want 255", req_cycles); end
        n_cmp++; if (ibe !== 1'b1) begin n_bad++; $display("FAIL tmo_ibe: got %b want 1", ibe); end
        n_cmp++; if (bad_vaddr !== 32'hbfc0_0010) begin n_bad++; $display("FAIL tmo_bad_vaddr: got %h want bfc00010", bad_vaddr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_not_written: got %b want 0", inst_valid); end
        flush = 1'b1; settle();
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL tmo_flush_stall: got %b want 0", stall); end
        step();
        flush = 1'b0;
    endtask

    task automatic test_flush_mid_req();
        addr = 32'h8000_0100; settle();
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL fl_miss_stall: got %b want 1", stall); end
        step();
        n_cmp++; if (bus_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL fl_bus_addr: got %h want 00000100", bus_addr); end
        flush = 1'b1; addr = 32'h8000_0200; settle();
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid: got %b want 0", inst_valid); end
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL fl_req_stall: got %b want 1", stall); end
        step();
        flush = 1'b0; settle();
        n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL fl_req_held1: got %b want 1", bus_req); end
        n_cmp++; if (bus_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL fl_addr_stable: got %h want 00000100", bus_addr); end
        step();
        n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL fl_req_held2: got %b want 1", bus_req); end
        step();
        bus_ack = 1'b1; bus_rdata = 32'hdead_beef;
        step();
        bus_ack = 1'b0; bus_rdata = 32'd0; addr = 32'h8000_0100; settle();
        n_cmp++; if (ibe !== 1'b0) begin n_bad++; $display("FAIL fl_no_ibe: got %b want 0", ibe); end
        n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL fl_req_dropped: got %b want 0", bus_req); end
        n_cmp++; if (dbg_state !== IFS_IDLE) begin n_bad++; $display("FAIL fl_state_idle: got %0d want %0d", dbg_state, IFS_IDLE); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL fl_not_written: got %b want 0", inst_valid); end
        addr = 32'h8000_0200; settle();
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL fl_refetch_stall: got %b want 1", stall); end
        step();
        n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL fl_refetch_req: got %b want 1", bus_req); end
        n_cmp++; if (bus_addr !== 32'h0000_0200) begin n_bad++; $display("FAIL fl_refetch_addr: got %h want 00000200", bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        step();
        bus_ack = 1'b0; bus_rdata = 32'd0; settle();
        n_cmp++; if (inst !== 32'h1111_2222) begin n_bad++; $display("FAIL fl_refetch_inst: got %h want 11112222", inst); end
        n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL fl_refetch_valid: got %b want 1", inst_valid); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fl_refetch_stall_done: got %b want 0", stall); end
    endtask

    initial begin
        test_reset();
        test_cold_fetch();
`ifdef IFETCH_PREFETCH_EN
        test_prefetch();
`endif
        test_hit();
        test_misaligned();
        test_bus_error();
        test_flush_mid_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
